// File: rtl/sfp_accum_pipe_if.sv
// Per-column psum stream into the SFP accumulator and its write stream toward the OFIFO.
interface sfp_accum_pipe_if #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16
);
    logic [col-1:0]         valid_in;
    logic [col*psum_bw-1:0] in_psum;
    logic                   ofifo_full;
    logic [col*psum_bw-1:0] out_accum;
    logic [col-1:0]         wr_ofifo;
    logic                   o_valid;

    modport master (
        output valid_in,
        output in_psum,
        output ofifo_full,
        input  out_accum,
        input  wr_ofifo,
        input  o_valid
    );

    modport slave (
        input  valid_in,
        input  in_psum,
        input  ofifo_full,
        output out_accum,
        output wr_ofifo,
        output o_valid
    );
endinterface

// File: rtl/sfp_accum_pipe.sv
// Per-column multi-pass psum accumulator with optional ReLU, sequenced over a run of groups.
// Define SFP_ACCUM_SAT_EN to saturate accumulation and emission instead of wrapping.
module sfp_accum_pipe #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned acc_bw  = 20,
    parameter int unsigned pass_w  = 4,
    parameter int unsigned grp_w   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [pass_w-1:0] num_pass,
    input  logic [grp_w-1:0]  num_groups,
    input  logic              relu_en,
    sfp_accum_pipe_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic              err_drop
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

`ifdef SFP_ACCUM_SAT_EN
    localparam logic signed [acc_bw-1:0] PsumMax =
        {{(acc_bw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
    localparam logic signed [acc_bw-1:0] PsumMin = ~PsumMax;
`endif

    state_e                    state_q;
    logic [pass_w-1:0]         np_q;
    logic [grp_w-1:0]          ng_q;
    logic [grp_w-1:0]          grp_q;
    logic [col-1:0]            mask_q;
    logic [pass_w-1:0]         pcnt_q [col];
    logic signed [acc_bw-1:0]  acc_q [col];
    logic [col*psum_bw-1:0]    out_accum_q;
    logic [col-1:0]            wr_ofifo_q;
    logic                      o_valid_q;
    logic                      err_drop_q;

    logic signed [psum_bw-1:0] psum [col];
    logic signed [acc_bw-1:0]  in_ext [col];
    logic signed [acc_bw-1:0]  sum [col];
    logic [psum_bw-1:0]        red [col];
    logic [col-1:0]            fin;
    logic                      run;
    logic                      complete;

    function automatic logic signed [acc_bw-1:0] acc_add(input logic signed [acc_bw-1:0] a,
                                                         input logic signed [acc_bw-1:0] b);
`ifdef SFP_ACCUM_SAT_EN
        logic [acc_bw:0] s;
        s = {a[acc_bw-1], a} + {b[acc_bw-1], b};
        if (s[acc_bw] != s[acc_bw-1]) begin
            return s[acc_bw] ? {1'b1, {(acc_bw-1){1'b0}}} : {1'b0, {(acc_bw-1){1'b1}}};
        end
        return s[acc_bw-1:0];
`else
        return a + b;
`endif
    endfunction

    always_comb begin
        run = (state_q == StRun) && !start;
        fin = '0;
        for (int c = 0; c < int'(col); c++) begin
            psum[c]   = bus.in_psum[c*psum_bw +: psum_bw];
            in_ext[c] = acc_bw'(psum[c]);
            sum[c]    = (pcnt_q[c] == '0) ? in_ext[c] : acc_add(acc_q[c], in_ext[c]);
            fin[c]    = run && bus.valid_in[c] && (pcnt_q[c] == np_q - pass_w'(1));
`ifdef SFP_ACCUM_SAT_EN
            if (sum[c] > PsumMax) begin
                red[c] = PsumMax[psum_bw-1:0];
            end else if (sum[c] < PsumMin) begin
                red[c] = PsumMin[psum_bw-1:0];
            end else begin
                red[c] = sum[c][psum_bw-1:0];
            end
`else
            red[c] = sum[c][psum_bw-1:0];
`endif
            if (relu_en && sum[c][acc_bw-1]) begin
                red[c] = '0;
            end
        end
        // A group closes once every column has emitted, counting this cycle's emits.
        complete = (|fin) && (&(mask_q | fin));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            np_q        <= '0;
            ng_q        <= '0;
            grp_q       <= '0;
            mask_q      <= '0;
            out_accum_q <= '0;
            wr_ofifo_q  <= '0;
            o_valid_q   <= 1'b0;
            err_drop_q  <= 1'b0;
            for (int c = 0; c < int'(col); c++) begin
                pcnt_q[c] <= '0;
                acc_q[c]  <= '0;
            end
        end else begin
            wr_ofifo_q <= '0;
            o_valid_q  <= 1'b0;
            if (start) begin
                // Start from any state restarts the run and discards partial sums.
                state_q    <= StRun;
                np_q       <= (num_pass == '0) ? pass_w'(1) : num_pass;
                ng_q       <= (num_groups == '0) ? grp_w'(1) : num_groups;
                grp_q      <= '0;
                mask_q     <= '0;
                err_drop_q <= 1'b0;
                for (int c = 0; c < int'(col); c++) begin
                    pcnt_q[c] <= '0;
                    acc_q[c]  <= '0;
                end
            end else begin
                unique case (state_q)
                    StIdle:  state_q <= StIdle;
                    StRun:   if (grp_q == ng_q) state_q <= StDone;
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase

                if (run) begin
                    for (int c = 0; c < int'(col); c++) begin
                        if (bus.valid_in[c]) begin
                            acc_q[c] <= sum[c];
                            if (fin[c]) begin
                                pcnt_q[c]                           <= '0;
                                out_accum_q[c*psum_bw +: psum_bw]   <= red[c];
                                wr_ofifo_q[c]                       <= !bus.ofifo_full;
                            end else begin
                                pcnt_q[c] <= pcnt_q[c] + pass_w'(1);
                            end
                        end
                    end
                end

                if (|fin) begin
                    if (bus.ofifo_full || (|(fin & mask_q))) begin
                        err_drop_q <= 1'b1;
                    end
                    if (complete) begin
                        o_valid_q <= 1'b1;
                        mask_q    <= '0;
                        grp_q     <= grp_q + grp_w'(1);
                    end else begin
                        mask_q <= mask_q | fin;
                    end
                end
            end
        end
    end

    assign bus.out_accum = out_accum_q;
    assign bus.wr_ofifo  = wr_ofifo_q;
    assign bus.o_valid   = o_valid_q;
    assign busy          = (state_q == StRun);
    assign done          = (state_q == StDone);
    assign err_drop      = err_drop_q;

endmodule

// File: tb/tb_sfp_accum_pipe.sv
// Directed bench for sfp_accum_pipe: a small pass model pushes expected writes to a scoreboard
// that a negedge monitor pops against the OFIFO write stream.
module tb_sfp_accum_pipe;
    localparam int Col = 8;
    localparam int Pb  = 16;

    logic       clk;
    logic       reset;
    logic       start;
    logic       relu_en;
    logic [3:0] num_pass;
    logic [7:0] num_groups;
    logic       busy;
    logic       done;
    logic       err_drop;

    sfp_accum_pipe_if #(.col(Col), .psum_bw(Pb)) bus ();

    sfp_accum_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_pass   (num_pass),
        .num_groups (num_groups),
        .relu_en    (relu_en),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err_drop   (err_drop)
    );

    typedef struct {
        int            c;
        logic [Pb-1:0] v;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   fails;
    int   ovalid_cnt;
    int   ov0;
    int   vv[Col];
    int   mdl_acc[Col];
    int   mdl_pcnt[Col];
    int   mdl_np;
    logic [Pb-1:0] sat_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [Pb-1:0] reduce_exp(input int s);
        logic [31:0] w;
        if (relu_en && s < 0) return '0;
`ifdef SFP_ACCUM_SAT_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        w = s;
        return w[Pb-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int v);
        for (int c = 0; c < Col; c++) vv[c] = v;
    endtask

    task automatic drive(input logic [Col-1:0] vm);
        exp_t e;
        bus.valid_in = vm;
        for (int c = 0; c < Col; c++) begin
            bus.in_psum[c*Pb +: Pb] = Pb'(vv[c]);
            if (vm[c]) begin
                if (mdl_pcnt[c] == 0) mdl_acc[c] = vv[c];
                else mdl_acc[c] += vv[c];
                if (mdl_pcnt[c] == mdl_np - 1) begin
                    mdl_pcnt[c] = 0;
                    if (!bus.ofifo_full) begin
                        e.c = c;
                        e.v = reduce_exp(mdl_acc[c]);
                        sb.push_back(e);
                    end
                end else begin
                    mdl_pcnt[c]++;
                end
            end
        end
        tick();
        bus.valid_in = '0;
    endtask

    task automatic do_start(input logic [3:0] np, input logic [7:0] ng);
        start      = 1'b1;
        num_pass   = np;
        num_groups = ng;
        tick();
        start  = 1'b0;
        mdl_np = (np == 0) ? 1 : int'(np);
        for (int c = 0; c < Col; c++) begin
            mdl_pcnt[c] = 0;
            mdl_acc[c]  = 0;
        end
    endtask

    task automatic finish_run();
        tick();
        check("done_pulse", done, 1'b1);
        check("busy_in_done", busy, 1'b0);
        tick();
        check("done_clears", done, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            for (int c = 0; c < Col; c++) begin
                if (bus.wr_ofifo[c]) begin
                    check("sb_has_entry", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("wr_column", c, e.c);
                        check("wr_value", bus.out_accum[c*Pb +: Pb], e.v);
                    end
                end
            end
            if (bus.o_valid) ovalid_cnt++;
        end
    end

    initial begin
        tests          = 0;
        fails          = 0;
        ovalid_cnt     = 0;
        reset          = 1'b1;
        start          = 1'b0;
        relu_en        = 1'b0;
        num_pass       = '0;
        num_groups     = '0;
        bus.valid_in   = '0;
        bus.in_psum    = '0;
        bus.ofifo_full = 1'b0;
        mdl_np         = 1;
        set_all(0);
        for (int c = 0; c < Col; c++) begin
            mdl_pcnt[c] = 0;
            mdl_acc[c]  = 0;
        end
        repeat (2) tick();
        check("rst_out_accum", bus.out_accum, '0);
        check("rst_wr_ofifo", bus.wr_ofifo, '0);
        check("rst_o_valid", bus.o_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err_drop", err_drop, 1'b0);
        reset = 1'b0;
        tick();

        // Three passes, all columns aligned.
        ov0 = ovalid_cnt;
        do_start(4'd3, 8'd1);
        check("busy_after_start", busy, 1'b1);
        set_all(5);  drive('1);
        set_all(-2); drive('1);
        set_all(7);  drive('1);
        check("np3_out", bus.out_accum, {8{16'd10}});
        check("np3_wr", bus.wr_ofifo, 8'hFF);
        check("np3_o_valid", bus.o_valid, 1'b1);
        finish_run();
        check("np3_ovalid_count", ovalid_cnt - ov0, 1);

        // Skewed columns, two groups.
        ov0 = ovalid_cnt;
        do_start(4'd2, 8'd2);
        for (int g = 0; g < 2; g++) begin
            for (int t = 0; t <= Col; t++) begin
                logic [Col-1:0] vm;
                logic [Col-1:0] wexp;
                vm = '0;
                for (int c = 0; c < Col; c++) begin
                    if (t == c)     begin vm[c] = 1'b1; vv[c] = 1; end
                    if (t == c + 1) begin vm[c] = 1'b1; vv[c] = 2; end
                end
                drive(vm);
                wexp = '0;
                if (t >= 1) wexp[t-1] = 1'b1;
                check("skew_wr_walk", bus.wr_ofifo, wexp);
                check("skew_o_valid", bus.o_valid, t == Col);
            end
            if (g == 0) check("skew_busy_mid", busy, 1'b1);
        end
        check("skew_out", bus.out_accum, {8{16'd3}});
        finish_run();
        check("skew_ovalid_count", ovalid_cnt - ov0, 2);

        // ReLU on and off.
        relu_en = 1'b1;
        do_start(4'd2, 8'd1);
        set_all(-9); drive('1);
        set_all(4);  drive('1);
        check("relu_on_out", bus.out_accum, '0);
        finish_run();
        relu_en = 1'b0;
        do_start(4'd2, 8'd1);
        set_all(-9); drive('1);
        set_all(4);  drive('1);
        check("relu_off_out", bus.out_accum, {8{16'hFFFB}});
        finish_run();

        // Dropped write on column 3.
        ov0 = ovalid_cnt;
        do_start(4'd2, 8'd1);
        set_all(3);
        drive('1);
        drive(8'hF7);
        check("drop_pre_wr", bus.wr_ofifo, 8'hF7);
        check("drop_pre_err", err_drop, 1'b0);
        bus.ofifo_full = 1'b1;
        drive(8'h08);
        bus.ofifo_full = 1'b0;
        check("drop_wr3", bus.wr_ofifo, 8'h00);
        check("drop_err", err_drop, 1'b1);
        check("drop_o_valid", bus.o_valid, 1'b1);
        finish_run();
        check("drop_err_sticky", err_drop, 1'b1);
        check("drop_ovalid_count", ovalid_cnt - ov0, 1);

        // Overflow of the emitted width.
        do_start(4'd2, 8'd1);
        check("start_clears_err", err_drop, 1'b0);
        set_all(28672);
        drive('1);
        drive('1);
`ifdef SFP_ACCUM_SAT_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'hE000;
`endif
        check("overflow_out", bus.out_accum, {8{sat_exp}});
        finish_run();

        // Restart mid-group discards the stale partial sum.
        do_start(4'd3, 8'd1);
        set_all(9);
        drive('1);
        do_start(4'd3, 8'd1);
        set_all(4);
        drive('1);
        drive('1);
        check("restart_no_early_wr", bus.wr_ofifo, 8'h00);
        drive('1);
        check("restart_out", bus.out_accum, {8{16'd12}});
        check("restart_o_valid", bus.o_valid, 1'b1);
        finish_run();

        // Zero pass and group counts behave as one.
        do_start(4'd0, 8'd0);
        set_all(-7);
        drive('1);
        check("np0_out", bus.out_accum, {8{16'hFFF9}});
        check("np0_o_valid", bus.o_valid, 1'b1);
        finish_run();

        // Asynchronous reset right after an emission.
        do_start(4'd1, 8'd1);
        set_all(5);
        drive('1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("areset_out", bus.out_accum, '0);
        check("areset_wr", bus.wr_ofifo, '0);
        check("areset_o_valid", bus.o_valid, 1'b0);
        check("areset_busy", busy, 1'b0);
        check("areset_done", done, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
